// File: rtl/mix_bias_pkg.sv
// Shared types and the saturating adder for the mix-layer bias stage.
package mix_bias_pkg;

    localparam int N_LEN   = 16;
    localparam int HID_DIM = 8;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    // One extra bit of headroom; disagreement of the top two bits means overflow.
    function automatic logic [N_LEN-1:0] sat_add(input logic [N_LEN-1:0] a,
                                                 input logic [N_LEN-1:0] b);
        logic [N_LEN:0] s;
        s = {a[N_LEN-1], a} + {b[N_LEN-1], b};
        if (s[N_LEN] != s[N_LEN-1])
            return s[N_LEN] ? {1'b1, {(N_LEN-1){1'b0}}} : {1'b0, {(N_LEN-1){1'b1}}};
        return s[N_LEN-1:0];
    endfunction

endpackage

// File: rtl/mix_bias_add.sv
// Bias-add stage of the mix layer: prefetches the per-lane bias ROM and adds it with saturation.
// MIX_BIAS_RELU_EN clamps negative results to zero. W must equal mix_bias_pkg::N_LEN.
module mix_bias_add
    import mix_bias_pkg::*;
#(
    parameter int N_LAYERS = 3,
    parameter int DIM      = HID_DIM,
    parameter int W        = N_LEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   layer_sel,
    input  logic [W-1:0] acc_in,
    input  logic         valid_in,
    output logic         ready_in,
    output logic [W-1:0] bias_addr,
    input  logic [W-1:0] bias_in,
    output logic [W-1:0] data_out,
    output logic         valid_out,
    input  logic         ready_out,
    output logic         last_out,
    output logic         busy,
    output logic         done
);

    state_t       state;
    logic [W-1:0] base, idx, base_nxt, idx_nxt, biased;
    logic         start_ok, accept, is_last;

    assign start_ok = (state == IDLE) && start && (int'(layer_sel) < N_LAYERS);
    assign ready_in = (state == RUN) && (!valid_out || ready_out);
    assign accept   = valid_in && ready_in;
    assign is_last  = (idx == W'(DIM - 1));

    // The ROM has one cycle of latency, so address it with the values idx/base take next.
    always_comb begin
        base_nxt = base;
        idx_nxt  = idx;
        if (!rst_n) begin
            base_nxt = '0;
            idx_nxt  = '0;
        end else if (start_ok) begin
            base_nxt = W'(int'(layer_sel) * DIM);
            idx_nxt  = '0;
        end else if (accept) begin
            idx_nxt  = idx + W'(1);
        end
    end

    assign bias_addr = base_nxt + idx_nxt;

    always_comb begin
        biased = sat_add(acc_in, bias_in);
`ifdef MIX_BIAS_RELU_EN
        if (biased[W-1])
            biased = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            idx       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            base <= base_nxt;
            idx  <= idx_nxt;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        data_out  <= biased;
                        valid_out <= 1'b1;
                        last_out  <= is_last;
                        if (is_last)
                            state <= FLUSH;
                    end else if (ready_out) begin
                        valid_out <= 1'b0;
                        last_out  <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (valid_out && ready_out) begin
                        valid_out <= 1'b0;
                        last_out  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_bias_add.sv
// Randomized bench for mix_bias_add with a 1-cycle-latency bias ROM model.
module tb_mix_bias_add;
    import mix_bias_pkg::*;

    localparam int W     = N_LEN;
    localparam int DIM   = HID_DIM;
    localparam int NL    = 3;
    localparam int DEPTH = NL * DIM;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   layer_sel = '0;
    logic [W-1:0] acc_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_in;
    logic [W-1:0] bias_addr;
    logic [W-1:0] bias_in = '0;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         ready_out = 1'b1;
    logic         last_out;
    logic         busy;
    logic         done;

    mix_bias_add #(.N_LAYERS(NL), .DIM(DIM), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_sel(layer_sel),
        .acc_in(acc_in), .valid_in(valid_in), .ready_in(ready_in),
        .bias_addr(bias_addr), .bias_in(bias_in), .data_out(data_out),
        .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] rom [DEPTH];
    always @(posedge clk)
        bias_in <= (int'(bias_addr) < DEPTH) ? rom[bias_addr] : '0;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] acc_v [DIM];
    logic [W-1:0] got_d [$];
    logic         got_l [$];
    int           got_c [$];
    int           acc_c [DIM];
    int           done_cnt, stall_bad;
    logic         timed_out;

    // Reference: plain integer sum clamped to the signed W-bit range.
    function automatic logic [W-1:0] ref_out(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
        if (s < -(1 << (W-1)))    s = -(1 << (W-1));
`ifdef MIX_BIAS_RELU_EN
        if (s < 0) s = 0;
`endif
        return W'(s);
    endfunction

    task automatic fill_random;
        for (int k = 0; k < DEPTH; k++) rom[k] = W'($urandom);
        for (int k = 0; k < DIM; k++)   acc_v[k] = W'($urandom);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // mode: 0 ready_out=1, 1 toggles 1010.., 2 random. restart_at/abort_at < 0 disables.
    task automatic run_vec(input int layer, input int mode, input int gap_pct,
                           input int restart_at, input int abort_at);
        int   i = 0, cyc = 0, post = 0;
        logic hold_chk = 1'b0, took, restarted = 1'b0;
        logic [W-1:0] held = '0;
        got_d.delete(); got_l.delete(); got_c.delete();
        done_cnt = 0; stall_bad = 0; timed_out = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; layer_sel = layer[1:0]; valid_in = 1'b0; ready_out = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 2000) begin
            if (!valid_in && i < DIM && int'($urandom_range(99)) >= gap_pct) begin
                valid_in = 1'b1; acc_in = acc_v[i];
            end
            ready_out = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
            if (restart_at >= 0 && !restarted && i == restart_at) begin
                start = 1'b1; layer_sel = 2'd2; restarted = 1'b1;
            end
            @(negedge clk);
            if (hold_chk && (!valid_out || data_out !== held)) stall_bad++;
            hold_chk = valid_out && !ready_out;
            held     = data_out;
            if (done) done_cnt++;
            if (valid_out && ready_out) begin
                got_d.push_back(data_out); got_l.push_back(last_out); got_c.push_back(cyc);
            end
            took = valid_in && ready_in;
            if (took) begin acc_c[i] = cyc; i++; end
            @(posedge clk); #1;
            start = 1'b0;
            if (took) valid_in = 1'b0;
            if (abort_at >= 0 && i == abort_at) begin timed_out = 1'b0; return; end
            if (done_cnt > 0) post++;
            if (post == 3) begin timed_out = 1'b0; break; end
            cyc++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_out !== '0)  begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
        checks++; if (valid_out !== 0)  begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (last_out !== 0)   begin errors++; $display("FAIL reset_last: got %b want 0", last_out); end
        checks++; if (busy !== 0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bias_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bias_addr); end
        checks++; if (ready_in !== 0)   begin errors++; $display("FAIL reset_ready: got %b want 0", ready_in); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        fill_random();
        for (int k = 0; k < DIM; k++) begin rom[DIM + k] = W'(k); acc_v[k] = W'(16'h0100); end
        run_vec(1, 0, 0, -1, -1);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL stream_timeout: got %b want 0", timed_out); end
        checks++; if (got_d.size() != DIM) begin errors++; $display("FAIL stream_count: got %0d want %0d", got_d.size(), DIM); end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++; if (got_d[k] !== W'(16'h0100 + k)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, got_d[k], W'(16'h0100 + k)); end
            checks++; if (got_l[k] !== (k == DIM - 1)) begin errors++; $display("FAIL stream_last[%0d]: got %b want %b", k, got_l[k], k == DIM - 1); end
            if (k > 0) begin
                checks++; if (got_c[k] - got_c[k-1] != 1) begin errors++; $display("FAIL stream_rate[%0d]: gap %0d want 1", k, got_c[k] - got_c[k-1]); end
            end
        end
        if (got_c.size() > 0) begin
            checks++; if (got_c[0] - acc_c[0] != 1) begin errors++; $display("FAIL stream_latency: got %0d want 1", got_c[0] - acc_c[0]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stream_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_saturation;
        logic [W-1:0] want_neg;
        fill_random();
        rom[0] = W'(16'h0020); acc_v[0] = W'(16'h7FF0);
        rom[1] = W'(16'hFFE0); acc_v[1] = W'(16'h8010);
`ifdef MIX_BIAS_RELU_EN
        want_neg = W'(16'h0000);
`else
        want_neg = W'(16'h8000);
`endif
        run_vec(0, 0, 0, -1, -1);
        checks++; if (timed_out !== 0 || got_d.size() != DIM) begin errors++; $display("FAIL sat_count: got %0d want %0d", got_d.size(), DIM); end
        else begin
            checks++; if (got_d[0] !== W'(16'h7FFF)) begin errors++; $display("FAIL sat_pos: got %h want 7fff", got_d[0]); end
            checks++; if (got_d[1] !== want_neg) begin errors++; $display("FAIL sat_neg: got %h want %h", got_d[1], want_neg); end
            for (int k = 2; k < DIM; k++) begin
                checks++; if (got_d[k] !== ref_out(acc_v[k], rom[k])) begin errors++; $display("FAIL sat_rand[%0d]: got %h want %h", k, got_d[k], ref_out(acc_v[k], rom[k])); end
            end
        end
    endtask

    task automatic test_backpressure;
        for (int m = 1; m <= 2; m++) begin
            fill_random();
            run_vec(2, m, 30, -1, -1);
            checks++; if (timed_out !== 0 || got_d.size() != DIM) begin errors++; $display("FAIL bp_count[m%0d]: got %0d want %0d", m, got_d.size(), DIM); end
            else for (int k = 0; k < DIM; k++) begin
                checks++; if (got_d[k] !== ref_out(acc_v[k], rom[2*DIM + k])) begin errors++; $display("FAIL bp_data[m%0d/%0d]: got %h want %h", m, k, got_d[k], ref_out(acc_v[k], rom[2*DIM + k])); end
            end
            checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable[m%0d]: got %0d changes want 0", m, stall_bad); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done[m%0d]: got %0d want 1", m, done_cnt); end
        end
    endtask

    task automatic test_bad_layer;
        do_reset();
        start = 1'b1; layer_sel = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (busy !== 0 || bias_addr !== '0) begin errors++; $display("FAIL badlayer[%0d]: busy %b addr %h want 0 0", c, busy, bias_addr); end
            @(posedge clk); #1;
        end
        fill_random();
        run_vec(1, 0, 20, DIM / 2, -1);
        checks++; if (timed_out !== 0 || got_d.size() != DIM) begin errors++; $display("FAIL restart_count: got %0d want %0d", got_d.size(), DIM); end
        else for (int k = 0; k < DIM; k++) begin
            checks++; if (got_d[k] !== ref_out(acc_v[k], rom[DIM + k])) begin errors++; $display("FAIL restart_data[%0d]: got %h want %h", k, got_d[k], ref_out(acc_v[k], rom[DIM + k])); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_mid_reset;
        fill_random();
        run_vec(2, 0, 0, -1, DIM / 2);
        rst_n = 1'b0; valid_in = 1'b0;
        @(posedge clk); #1;
        checks++; if (valid_out !== 0 || data_out !== '0 || last_out !== 0) begin errors++; $display("FAIL abort_out: valid %b data %h last %b want 0", valid_out, data_out, last_out); end
        checks++; if (busy !== 0 || done !== 0 || bias_addr !== '0) begin errors++; $display("FAIL abort_ctl: busy %b done %b addr %h want 0", busy, done, bias_addr); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_nodone: got %0d want 0", done_cnt); end
        rst_n = 1'b1;
        fill_random();
        run_vec(0, 2, 10, -1, -1);
        checks++; if (timed_out !== 0 || got_d.size() != DIM) begin errors++; $display("FAIL after_abort_count: got %0d want %0d", got_d.size(), DIM); end
        else for (int k = 0; k < DIM; k++) begin
            checks++; if (got_d[k] !== ref_out(acc_v[k], rom[k])) begin errors++; $display("FAIL after_abort_data[%0d]: got %h want %h", k, got_d[k], ref_out(acc_v[k], rom[k])); end
        end
    endtask

    task automatic test_relu;
        logic [W-1:0] want;
`ifdef MIX_BIAS_RELU_EN
        want = W'(16'h0000);
`else
        want = W'(16'hFFFF);
`endif
        fill_random();
        rom[0] = W'(16'hFFFF); acc_v[0] = '0;
        run_vec(0, 0, 0, -1, -1);
        checks++; if (got_d.size() == 0 || got_d[0] !== want) begin errors++; $display("FAIL relu_sign: got %h want %h", got_d.size() ? got_d[0] : 'x, want); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_saturation();
        test_backpressure();
        test_bad_layer();
        test_mid_reset();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
